// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA types, default timing constants
// and a width helper used by the frame reader and sync core.
package vga_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_V_DISPLAY = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } rd_state_e;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: memory read port and line buffer
// source port of the frame reader.
interface vga_frame_reader_if #(
  parameter int RGB_SIZE = 12,
  parameter int AW       = 19
);

  logic                mem_rd;
  logic [AW-1:0]       mem_addr;
  logic                mem_ready;
  logic                mem_rvld;
  logic [RGB_SIZE-1:0] mem_rdata;
  logic [RGB_SIZE:0]   line_buffer_data;
  logic                line_buffer_vld;
  logic                line_buffer_rdy;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_ready,
    input  mem_rvld,
    input  mem_rdata,
    output line_buffer_data,
    output line_buffer_vld,
    input  line_buffer_rdy
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_ready,
    output mem_rvld,
    output mem_rdata,
    input  line_buffer_data,
    input  line_buffer_vld,
    output line_buffer_rdy
  );

endinterface

// File: rtl/vga_sync_fifo.sv
// vga_sync_fifo: single-clock FIFO, power-of-two DEPTH,
// with occupancy count and empty/full flags.
module vga_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: streams a linear framebuffer into the line buffer.
// Option VGA_FRAME_READER_DOUBLE_BUFFER_EN adds fb_sel page flipping.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int RGB_SIZE   = 12,
  parameter int H_DISPLAY  = DEF_H_DISPLAY,
  parameter int V_DISPLAY  = DEF_V_DISPLAY,
  parameter int AW         = 19,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic enable,
`ifdef VGA_FRAME_READER_DOUBLE_BUFFER_EN
  input  logic fb_sel,
`endif
  output logic busy,
  output logic frame_done,
  vga_frame_reader_if.master bus
);

  localparam int HW   = cw(H_DISPLAY);
  localparam int VW   = cw(V_DISPLAY);
  localparam int NPIX = H_DISPLAY * V_DISPLAY;
  localparam int PW   = cw(NPIX);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  rd_state_e         state;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [AW-1:0]     addr_q;
  logic [AW-1:0]     base;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic [PW-1:0]     pix_out;
  logic              sof_pend;
  logic              fifo_empty;
  logic              fifo_full;
  logic [RGB_SIZE:0] fifo_dout;
  logic              req_ok;
  logic              accept;
  logic              rsp;
  logic              pop;
  logic              h_last;
  logic              v_last;
  logic              start;

`ifdef VGA_FRAME_READER_DOUBLE_BUFFER_EN
  assign base = fb_sel ? AW'(BASE_ADDR + NPIX)
                       : AW'(BASE_ADDR);
`else
  assign base = AW'(BASE_ADDR);
`endif

  // Credits cover both in-flight reads and FIFO
  // occupancy, so a response always has a slot.
  assign req_ok = (state == ST_FETCH) & ~fifo_full &
                  (({1'b0, outstanding} + {1'b0, fifo_count})
                   < (CW+1)'(FIFO_DEPTH));

  assign accept = req_ok & bus.mem_ready;
  assign rsp    = bus.mem_rvld & (outstanding != '0);
  assign pop    = ~fifo_empty & bus.line_buffer_rdy;
  assign h_last = (h_cnt == HW'(H_DISPLAY - 1));
  assign v_last = (v_cnt == VW'(V_DISPLAY - 1));

  assign frame_done = (state == ST_DRAIN) & pop &
                      (pix_out == PW'(NPIX - 1)) &
                      (outstanding == '0);

  assign start = enable &
                 ((state == ST_IDLE) |
                  ((state == ST_DRAIN) & frame_done));

  assign busy                 = (state != ST_IDLE);
  assign bus.mem_rd           = req_ok;
  assign bus.mem_addr         = addr_q;
  assign bus.line_buffer_vld  = ~fifo_empty;
  assign bus.line_buffer_data = fifo_empty ? '0 : fifo_dout;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      addr_q      <= '0;
      outstanding <= '0;
      pix_out     <= '0;
      sof_pend    <= 1'b0;
    end else begin
      unique case ({accept, rsp})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (rsp) sof_pend <= 1'b0;
      if (pop) pix_out <= pix_out + 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (enable) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (accept) begin
            addr_q <= addr_q + 1'b1;
            if (h_last) begin
              h_cnt <= '0;
              v_cnt <= v_cnt + 1'b1;
              if (v_last) state <= ST_DRAIN;
            end else begin
              h_cnt <= h_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (frame_done)
            state <= enable ? ST_FETCH : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // frame start overrides the per-cycle updates above
      if (start) begin
        h_cnt    <= '0;
        v_cnt    <= '0;
        addr_q   <= base;
        sof_pend <= 1'b1;
        pix_out  <= '0;
      end
    end
  end

  vga_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RGB_SIZE + 1)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (rsp),
    .din   ({sof_pend, bus.mem_rdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: scoreboard bench, 4x2 frame, 4-deep FIFO,
// memory returns addr+0x100 two cycles after accept.
module tb_vga_frame_reader;

  localparam int RGB = 12;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int AW  = 5;
  localparam int FD  = 4;

  typedef struct packed {
    logic [RGB:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sys_rst;
  logic enable;
  logic busy;
  logic frame_done;
  logic toggle_mode;
  logic inject;
`ifdef VGA_FRAME_READER_DOUBLE_BUFFER_EN
  logic fb_sel;
`endif

  vga_frame_reader_if #(.RGB_SIZE(RGB), .AW(AW)) bus ();

  vga_frame_reader #(
    .RGB_SIZE   (RGB),
    .H_DISPLAY  (H),
    .V_DISPLAY  (V),
    .AW         (AW),
    .BASE_ADDR  (0),
    .FIFO_DEPTH (FD)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
`ifdef VGA_FRAME_READER_DOUBLE_BUFFER_EN
    .fb_sel     (fb_sel),
`endif
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  exp_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;
  int fd_cnt   = 0;
  int req_cnt  = 0;

  // memory model: in-order, latency 2
  initial begin
    logic s1, s2, acc;
    logic [AW-1:0] a1, a2;
    s1 = 0; s2 = 0; a1 = '0; a2 = '0;
    bus.mem_ready = 1'b1;
    bus.mem_rvld  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = toggle_mode ? ~bus.mem_ready : 1'b1;
      acc = bus.mem_rd & bus.mem_ready;
      bus.mem_rvld  = s2 | inject;
      bus.mem_rdata = inject ? 12'hbad
                             : 12'h100 + 12'(a2);
      s2 = s1; a2 = a1;
      s1 = acc; a1 = bus.mem_addr;
    end
  end

  // monitor: pops expectations as the DUT produces
  initial begin
    logic pv, pr;
    logic [RGB:0] pd;
    exp_t e;
    logic [AW-1:0] ea;
    pv = 0; pr = 0; pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!sys_rst) begin
        if (pv && !pr) begin
          checks++;
          if (!bus.line_buffer_vld ||
              bus.line_buffer_data != pd) begin
            failures++;
            $display("FAIL stall_hold: vld=%0b data=%0h need 1/%0h",
                     bus.line_buffer_vld,
                     bus.line_buffer_data, pd);
          end
        end
        if (bus.mem_rd && bus.mem_ready) begin
          req_cnt++;
          checks++;
          if (addr_q.size() == 0) begin
            failures++;
            $display("FAIL req_addr: extra addr %0d",
                     bus.mem_addr);
          end else begin
            ea = addr_q.pop_front();
            if (bus.mem_addr != ea) begin
              failures++;
              $display("FAIL req_addr: got %0d need %0d",
                       bus.mem_addr, ea);
            end
          end
        end
        if (bus.line_buffer_vld && bus.line_buffer_rdy) begin
          out_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_data: extra %0h",
                     bus.line_buffer_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.line_buffer_data != e.data ||
                frame_done != e.last) begin
              failures++;
              $display("FAIL out_data: got %0h/fd%0b need %0h/fd%0b",
                       bus.line_buffer_data, frame_done,
                       e.data, e.last);
            end
          end
        end else if (frame_done) begin
          checks++;
          failures++;
          $display("FAIL frame_done: pulse without accept got 1 need 0");
        end
        if (frame_done) fd_cnt++;
        pv = bus.line_buffer_vld;
        pr = bus.line_buffer_rdy;
        pd = bus.line_buffer_data;
      end else begin
        pv = 0;
        pr = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h need %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input int base);
    exp_t e;
    for (int k = 0; k < H * V; k++) begin
      e.data = {(k == 0), 12'(12'h100 + base + k)};
      e.last = (k == H * V - 1);
      exp_q.push_back(e);
      addr_q.push_back(AW'(base + k));
    end
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < lim) begin
      cyc();
      n++;
    end
    check(name, {31'd0, n < lim}, 32'd1);
    check({name, "_addrs"}, addr_q.size(), 0);
  endtask

  task automatic wait_outs(input int target, input int lim);
    int n = 0;
    while (out_cnt < target && n < lim) begin
      cyc();
      n++;
    end
    check("wait_outs", {31'd0, n < lim}, 32'd1);
  endtask

  task automatic wait_fd(input int target, input int lim);
    int n = 0;
    while (fd_cnt < target && n < lim) begin
      cyc();
      n++;
    end
    check("wait_fd", {31'd0, n < lim}, 32'd1);
  endtask

  function automatic logic [31:0] out_vec();
    return {11'd0, busy, frame_done, bus.mem_rd,
            bus.mem_addr, bus.line_buffer_vld,
            bus.line_buffer_data};
  endfunction

  initial begin
    int fd0, o0, r0;
    sys_rst = 1'b1;
    enable = 1'b0;
    toggle_mode = 1'b0;
    inject = 1'b0;
    bus.line_buffer_rdy = 1'b1;
`ifdef VGA_FRAME_READER_DOUBLE_BUFFER_EN
    fb_sel = 1'b0;
`endif
    repeat (3) cyc();
    check("reset_outs", out_vec(), 0);
    sys_rst = 1'b0;
    cyc();

    // free-flowing single frame
    fd0 = fd_cnt; o0 = out_cnt;
    push_frame(0);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    wait_idle("free_done", 200);
    check("free_fd", fd_cnt - fd0, 1);
    check("free_outs", out_cnt - o0, 8);
    check("free_busy", {31'd0, busy}, 0);

    // backpressure for 20 cycles from frame start
    fd0 = fd_cnt; r0 = req_cnt;
    bus.line_buffer_rdy = 1'b0;
    push_frame(0);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    repeat (19) cyc();
    check("bp_reqs", req_cnt - r0, 4);
    check("bp_fifo", dut.u_fifo.count, 4);
    check("bp_head", {19'd0, bus.line_buffer_vld,
                      bus.line_buffer_data}, 32'h3100);
    bus.line_buffer_rdy = 1'b1;
    wait_idle("bp_done", 200);
    check("bp_fd", fd_cnt - fd0, 1);

    // mem_ready toggling
    r0 = req_cnt;
    toggle_mode = 1'b1;
    push_frame(0);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    wait_idle("tog_done", 300);
    toggle_mode = 1'b0;
    check("tog_reqs", req_cnt - r0, 8);

    // continuous: two back-to-back frames
    fd0 = fd_cnt; o0 = out_cnt;
    push_frame(0);
    push_frame(0);
    enable = 1'b1;
    wait_fd(fd0 + 1, 200);
    enable = 1'b0;
    wait_idle("cont_done", 200);
    check("cont_fd", fd_cnt - fd0, 2);
    check("cont_outs", out_cnt - o0, 16);

    // reset mid-frame plus stale response
    o0 = out_cnt;
    push_frame(0);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    wait_outs(o0 + 3, 100);
    sys_rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    cyc();
    check("rst_outs", out_vec(), 0);
    sys_rst = 1'b0;
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_stale", {31'd0, bus.line_buffer_vld}, 0);
      cyc();
    end
    check("rst_fifo", dut.u_fifo.count, 0);
    fd0 = fd_cnt;
    push_frame(0);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    wait_idle("rst_done", 200);
    check("rst_fd", fd_cnt - fd0, 1);

`ifdef VGA_FRAME_READER_DOUBLE_BUFFER_EN
    // page 1, flip to page 0 mid-frame
    fd0 = fd_cnt; o0 = out_cnt;
    fb_sel = 1'b1;
    push_frame(8);
    push_frame(0);
    enable = 1'b1;
    cyc();
    wait_outs(o0 + 3, 100);
    fb_sel = 1'b0;
    wait_fd(fd0 + 1, 200);
    enable = 1'b0;
    wait_idle("db_done", 200);
    check("db_fd", fd_cnt - fd0, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
